// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage with a credit-checked in-order buffer,
//            valid/ready delivery to decode and redirect-driven flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int             PW      = $clog2(DEPTH);
  localparam int             CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]    DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [31:0]   buf_word [DEPTH];
  logic [31:0]   buf_pc   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          pop;
  logic          wr;
  logic [CW:0]   occupancy;

  assign instr_valid = (count != '0) & ~reset & ~redirect_valid;
  assign pop         = instr_valid & instr_ready;
  assign wr          = inflight & ~redirect_valid;

  // Slots already promised after this cycle: held entries plus the response
  // in flight, minus the entry leaving now. Issue only if one remains free.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign imem_en   = ~reset & ~redirect_valid & (occupancy < DEPTH_W);
  assign imem_addr = fetch_pc;

  assign instr    = buf_word[rd_ptr];
  assign instr_pc = buf_pc[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~32'h0000_0003;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_en;
      if (imem_en) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
      if (wr) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({wr, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only count decides what is visible.
  always_ff @(posedge clk) begin
    if (!reset && wr) begin
      buf_word[wr_ptr] <= imem_data;
      buf_pc[wr_ptr]   <= inflight_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit: queue-based reference model,
//            directed scenarios with literal expectations, random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending {word, pc} plus fetch PC state.
  typedef struct packed {
    logic [31:0] w;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  logic        m_infl;
  logic [31:0] m_infl_pc;
  bit          started = 0;
  logic        req_en = 1'b0;
  logic [31:0] req_addr = 32'h0;

  always @(negedge clk) begin
    bit e_valid, e_pop, e_en;
    if (started) begin
      e_valid = !reset && !redirect_valid && (q.size() != 0);
      e_pop   = e_valid && instr_ready;
      e_en    = !reset && !redirect_valid && ((q.size() + int'(m_infl) - int'(e_pop)) < DEPTH);
      check("m_imem_en", {31'b0, imem_en}, {31'b0, e_en});
      if (!reset) check("m_imem_addr", imem_addr, m_pc);
      check("m_instr_valid", {31'b0, instr_valid}, {31'b0, e_valid});
      if (e_valid) begin
        check("m_instr", instr, q[0].w);
        check("m_instr_pc", instr_pc, q[0].pc);
      end
      if (reset) begin
        // handled below
      end else if (redirect_valid) begin
        q.delete();
        m_infl = 1'b0;
        m_pc   = redirect_pc & ~32'h3;
      end else begin
        if (e_pop) void'(q.pop_front());
        if (m_infl) q.push_back('{w: memf(m_infl_pc), pc: m_infl_pc});
        if (e_en) begin
          m_infl_pc = m_pc;
          m_pc      = m_pc + 32'd4;
        end
        m_infl = e_en;
      end
    end
    if (reset) begin
      q.delete();
      m_pc      = RESET_PC;
      m_infl    = 1'b0;
      m_infl_pc = RESET_PC;
      started   = 1;
    end
    req_en   = imem_en;
    req_addr = imem_addr;
  end

  // One cycle: memory answers last cycle's request, then new inputs apply.
  task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    imem_data      = (req_en === 1'b1) ? memf(req_addr) : $urandom;
    reset          = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) cyc(1, 0, 0, 1);

    // Fill and stream from reset
    cyc(0, 0, 0, 1);
    check("c0_en", {31'b0, imem_en}, 32'd1);
    check("c0_addr", imem_addr, 32'h0);
    check("c0_valid", {31'b0, instr_valid}, 32'd0);
    cyc(0, 0, 0, 1);
    check("c1_addr", imem_addr, 32'h4);
    cyc(0, 0, 0, 1);
    check("c2_valid", {31'b0, instr_valid}, 32'd1);
    check("c2_instr", instr, 32'hA000_0000);
    check("c2_pc", instr_pc, 32'h0);
    for (int k = 3; k < 8; k++) begin
      cyc(0, 0, 0, 1);
      check("stream_pc", instr_pc, 32'(4 * (k - 2)));
    end

    // Redirect to an unaligned target while streaming
    cyc(0, 1, 32'h0000_0103, 1);
    check("rd0_valid", {31'b0, instr_valid}, 32'd0);
    check("rd0_en", {31'b0, imem_en}, 32'd0);
    cyc(0, 0, 0, 1);
    check("rd1_valid", {31'b0, instr_valid}, 32'd0);
    check("rd1_en", {31'b0, imem_en}, 32'd1);
    check("rd1_addr", imem_addr, 32'h100);
    cyc(0, 0, 0, 1);
    check("rd2_valid", {31'b0, instr_valid}, 32'd0);
    cyc(0, 0, 0, 1);
    check("rd3_pc", instr_pc, 32'h100);
    check("rd3_instr", instr, 32'hA000_0040);
    repeat (3) cyc(0, 0, 0, 1);

    // Redirect near the top of the address space
    cyc(0, 1, 32'hFFFF_FFF8, 1);
    repeat (2) cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
    cyc(0, 0, 0, 1);
    check("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 1);
    check("wrap_pc2", instr_pc, 32'h0000_0000);
    check("wrap_instr2", instr, 32'hA000_0000);

    // Reset mid-stream with a response outstanding
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_en", {31'b0, imem_en}, 32'd1);
    check("rst_addr", imem_addr, RESET_PC);

    // Backpressure from cycle 2 fills the buffer and freezes fetch
    cyc(0, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("bp_en", {31'b0, imem_en}, 32'd0);
    check("bp_addr", imem_addr, 32'h8);
    check("bp_pc", instr_pc, 32'h0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 1);
      check("bp_drain_pc", instr_pc, 32'(4 * k));
    end

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      logic        r, rv, rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 99) < 6);
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 9) < 6);
      cyc(r, rv, rpc, rdy);
    end

    cyc(0, 0, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
